// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage. Owns the PC, issues word fetches
// over a request/ready handshake, buffers one completed word while the
// pipeline is held, and loads the IF/ID register. Taken branches come back
// as Redirect/RedirectPc and override both stalls and normal completion.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic        IfIdValid,
  output logic [31:0] IfIdPc,
  output logic [31:0] IfIdInstr,
  output logic [31:0] PcP4
);

  // IDLE: nothing outstanding; BUSY: response wanted; DROP: response discarded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] redirect_tgt_s;

  // Next sequential word address; wraps mod 2^32.
  function automatic logic [31:0] word_inc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  // Branch targets are always word aligned; the low two bits are dropped.
  assign redirect_tgt_s = RedirectPc & 32'hFFFF_FFFC;

  // Next-state logic for the fetch FSM, PC, hold buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;

    if (Redirect) begin
      // Wrong-path work is squashed wherever it sits.
      ifid_valid_d = 1'b0;
      hold_valid_d = 1'b0;
      pc_d         = redirect_tgt_s;
      case (state_q)
        ST_BUSY, ST_DROP: begin
          if (ImemReady) begin
            if (!Stall) begin
              req_addr_d = redirect_tgt_s;
              state_d    = ST_BUSY;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            // Address must stay put until the memory answers; mark it stale.
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      // Without a load this cycle, an unstalled IF/ID becomes a bubble.
      ifid_valid_d = Stall ? ifid_valid_q : 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!Stall) begin
            if (hold_valid_q) begin
              ifid_valid_d = 1'b1;
              ifid_pc_d    = hold_pc_q;
              ifid_instr_d = hold_instr_q;
              hold_valid_d = 1'b0;
            end else begin
              hold_valid_d = 1'b0;
            end
            req_addr_d = pc_q;
            state_d    = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (ImemReady) begin
            pc_d = word_inc(req_addr_q);
            if (!Stall) begin
              ifid_valid_d = 1'b1;
              ifid_pc_d    = req_addr_q;
              ifid_instr_d = ImemRdata;
              req_addr_d   = word_inc(req_addr_q);
              state_d      = ST_BUSY;
            end else begin
              // Park the word; it is delivered when the stall releases.
              hold_valid_d = 1'b1;
              hold_pc_d    = req_addr_q;
              hold_instr_d = ImemRdata;
              state_d      = ST_IDLE;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DROP: begin
          if (ImemReady) begin
            if (!Stall) begin
              req_addr_d = pc_q;
              state_d    = ST_BUSY;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    imem_req_d = (state_d != ST_IDLE);
  end

  // State register with synchronous active-low reset; outputs come from flops.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q      <= ST_IDLE;
      imem_req_q   <= 1'b0;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= 32'h0000_0000;
      hold_instr_q <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign ImemReq   = imem_req_q;
  assign ImemAddr  = req_addr_q;
  assign IfIdValid = ifid_valid_q;
  assign IfIdPc    = ifid_pc_q;
  assign IfIdInstr = ifid_instr_q;
  assign PcP4      = word_inc(ifid_pc_q);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios followed by a randomized run checked
// against a program-order reference model (expected next PC, word contents
// derived from the address, handshake stability rules).
module tb_pc_fetch_unit;

  logic        Clk;
  logic        RstN;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemRdata;
  logic        IfIdValid;
  logic [31:0] IfIdPc;
  logic [31:0] IfIdInstr;
  logic [31:0] PcP4;

  int checks   = 0;
  int failures = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk       (Clk),
    .RstN      (RstN),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .RedirectPc(RedirectPc),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemReady (ImemReady),
    .ImemRdata (ImemRdata),
    .IfIdValid (IfIdValid),
    .IfIdPc    (IfIdPc),
    .IfIdInstr (IfIdInstr),
    .PcP4      (PcP4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  assign ImemRdata = mem_word(ImemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    RstN = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPc = 32'h0; ImemReady = 1'b0;
    tick();
    RstN = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, ImemReq}, 32'd0);
    chk({tag, "_addr"},  ImemAddr, 32'h0);
    chk({tag, "_valid"}, {31'd0, IfIdValid}, 32'd0);
    chk({tag, "_pc"},    IfIdPc, 32'h0);
    chk({tag, "_instr"}, IfIdInstr, 32'h0);
    chk({tag, "_pcp4"},  PcP4, 32'h4);
  endtask

  // model / history state for the random phase
  logic [31:0] exp_next;
  logic        p_stall, p_redir, p_req, p_ready, p_valid;
  logic [31:0] p_tgt, p_addr, p_pc, p_instr;
  int          retired;

  initial begin
    // ---------------- reset values
    do_reset();
    RstN = 1'b0;
    chk_reset_vals("reset");

    // ---------------- zero-wait stream
    RstN = 1'b1; ImemReady = 1'b1;
    tick();
    chk("zw_c1_req",  {31'd0, ImemReq}, 32'd1);
    chk("zw_c1_addr", ImemAddr, 32'h0);
    tick();
    chk("zw_c2_addr",  ImemAddr, 32'h4);
    chk("zw_c2_valid", {31'd0, IfIdValid}, 32'd1);
    chk("zw_c2_pc",    IfIdPc, 32'h0);
    chk("zw_c2_instr", IfIdInstr, mem_word(32'h0));
    tick();
    chk("zw_c3_addr", ImemAddr, 32'h8);
    chk("zw_c3_pc",   IfIdPc, 32'h4);
    chk("zw_c3_pcp4", PcP4, 32'h8);

    // ---------------- two wait cycles on 0x4
    do_reset();
    ImemReady = 1'b1;
    tick();
    tick();
    chk("ws_addr0", ImemAddr, 32'h4);
    ImemReady = 1'b0;
    tick();
    chk("ws_addr1",   ImemAddr, 32'h4);
    chk("ws_bubble1", {31'd0, IfIdValid}, 32'd0);
    tick();
    chk("ws_addr2",   ImemAddr, 32'h4);
    chk("ws_bubble2", {31'd0, IfIdValid}, 32'd0);
    ImemReady = 1'b1;
    tick();
    chk("ws_valid", {31'd0, IfIdValid}, 32'd1);
    chk("ws_pc",    IfIdPc, 32'h4);
    chk("ws_addr3", ImemAddr, 32'h8);

    // ---------------- redirect while 0x8 waits
    ImemReady = 1'b0; Redirect = 1'b1; RedirectPc = 32'h0000_0100;
    tick();
    Redirect = 1'b0;
    chk("rd_addr_held", ImemAddr, 32'h8);
    chk("rd_req",       {31'd0, ImemReq}, 32'd1);
    chk("rd_valid0",    {31'd0, IfIdValid}, 32'd0);
    tick();
    chk("rd_addr_held2", ImemAddr, 32'h8);
    chk("rd_valid1",     {31'd0, IfIdValid}, 32'd0);
    ImemReady = 1'b1;
    tick();
    chk("rd_new_addr", ImemAddr, 32'h100);
    chk("rd_valid2",   {31'd0, IfIdValid}, 32'd0);
    tick();
    chk("rd_tgt_valid", {31'd0, IfIdValid}, 32'd1);
    chk("rd_tgt_pc",    IfIdPc, 32'h100);
    chk("rd_tgt_instr", IfIdInstr, mem_word(32'h100));

    // ---------------- stall as 0xC completes
    do_reset();
    ImemReady = 1'b1;
    tick(); tick(); tick(); tick();
    chk("st_addr_c", ImemAddr, 32'hC);
    Stall = 1'b1;
    tick();
    chk("st_req0",   {31'd0, ImemReq}, 32'd0);
    chk("st_pc0",    IfIdPc, 32'h8);
    chk("st_valid0", {31'd0, IfIdValid}, 32'd1);
    tick();
    chk("st_req1", {31'd0, ImemReq}, 32'd0);
    chk("st_pc1",  IfIdPc, 32'h8);
    Stall = 1'b0;
    tick();
    chk("st_rel_valid", {31'd0, IfIdValid}, 32'd1);
    chk("st_rel_pc",    IfIdPc, 32'hC);
    chk("st_rel_instr", IfIdInstr, mem_word(32'hC));
    chk("st_rel_req",   {31'd0, ImemReq}, 32'd1);
    chk("st_rel_addr",  ImemAddr, 32'h10);

    // ---------------- redirect to top of address space, wrap
    Redirect = 1'b1; RedirectPc = 32'hFFFF_FFFF;
    tick();
    Redirect = 1'b0;
    chk("wr_addr_top", ImemAddr, 32'hFFFF_FFFC);
    chk("wr_valid0",   {31'd0, IfIdValid}, 32'd0);
    tick();
    chk("wr_pc_top", IfIdPc, 32'hFFFF_FFFC);
    chk("wr_pcp4",   PcP4, 32'h0);
    chk("wr_addr0",  ImemAddr, 32'h0);
    tick();
    chk("wr_pc0",   IfIdPc, 32'h0);
    chk("wr_addr4", ImemAddr, 32'h4);

    // ---------------- reset while in DROP with redirect asserted
    ImemReady = 1'b0; Redirect = 1'b1; RedirectPc = 32'h200;
    tick();
    chk("dr_req", {31'd0, ImemReq}, 32'd1);
    RstN = 1'b0; RedirectPc = 32'h300;
    tick();
    chk_reset_vals("dr_reset");
    RstN = 1'b1; Redirect = 1'b0; ImemReady = 1'b1;
    tick();
    chk("dr_first_req",  {31'd0, ImemReq}, 32'd1);
    chk("dr_first_addr", ImemAddr, 32'h0);
    tick();
    chk("dr_first_pc",    IfIdPc, 32'h0);
    chk("dr_first_valid", {31'd0, IfIdValid}, 32'd1);

    // ---------------- randomized run against the order model
    do_reset();
    tick();
    exp_next = 32'h0;
    retired  = 0;
    for (int c = 0; c < 3000; c++) begin
      Stall      = ($urandom_range(3) == 0);
      Redirect   = Redirect ? 1'b0 : ($urandom_range(19) == 0);
      RedirectPc = $urandom;
      ImemReady  = ImemReq ? ($urandom_range(9) < 6) : 1'b0;
      p_stall = Stall; p_redir = Redirect; p_tgt = RedirectPc;
      p_req = ImemReq; p_ready = ImemReady; p_addr = ImemAddr;
      p_valid = IfIdValid; p_pc = IfIdPc; p_instr = IfIdInstr;
      tick();
      chk("rnd_pcp4",  PcP4, IfIdPc + 32'd4);
      chk("rnd_align", {30'd0, ImemAddr[1:0]}, 32'd0);
      if (p_req && !p_ready) begin
        chk("rnd_addr_stable", ImemAddr, p_addr);
        chk("rnd_req_stable",  {31'd0, ImemReq}, 32'd1);
      end
      if (p_redir) begin
        chk("rnd_redir_squash", {31'd0, IfIdValid}, 32'd0);
        exp_next = {p_tgt[31:2], 2'b00};
      end else if (p_stall) begin
        chk("rnd_stall_valid", {31'd0, IfIdValid}, {31'd0, p_valid});
        chk("rnd_stall_pc",    IfIdPc, p_pc);
        chk("rnd_stall_instr", IfIdInstr, p_instr);
      end else if (IfIdValid) begin
        chk("rnd_order", IfIdPc, exp_next);
        chk("rnd_instr", IfIdInstr, mem_word(IfIdPc));
        exp_next = exp_next + 32'd4;
        retired++;
      end
    end
    chk("rnd_progress", {31'd0, (retired > 200)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the MIPS datapath. Owns the program counter, issues word fetches to instruction memory over a request/ready handshake, and loads the IF/ID pipeline register. It is the consumer of the branch-resolution result: the taken-branch select and target computed downstream come back here as `Redirect`/`RedirectPc`. It also returns `PcP4` of the instruction in IF/ID to the branch-target adder.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- RstN  in  1  reset, synchronous, active-low.
- Stall  in  1  hazard-unit hold: IF/ID keeps its contents and no new fetch is launched.
- Redirect  in  1  taken branch (Branch & ZeroFlag), single-cycle pulse.
- RedirectPc  in  32  branch target; bits [1:0] are ignored and treated as 0.
- ImemReq  out  1  fetch request outstanding.
- ImemAddr  out  32  fetch address; stable while ImemReq=1.
- ImemReady  in  1  response valid this cycle; completes the request.
- ImemRdata  in  32  instruction word; sampled only when ImemReady=1.
- IfIdValid  out  1  IF/ID holds a live instruction.
- IfIdPc  out  32  PC of the IF/ID instruction.
- IfIdInstr  out  32  IF/ID instruction word.
- PcP4  out  32  IfIdPc + 4, combinational, mod 2^32.

## Operation
- State: Pc (next address to fetch), ReqAddr (drives ImemAddr), one-entry hold buffer (HoldValid, HoldPc, HoldInstr), and FSM state.
- FSM states:
  - IDLE: nothing outstanding.
  - BUSY: request outstanding, response wanted.
  - DROP: request outstanding, response to be discarded.
- ImemReq = (state != IDLE).
- Launch means: ReqAddr <= address, state <= BUSY, and Pc <= address + 4 on completion.
- IDLE:
  - If Stall=0 and HoldValid=0, launch at Pc.
  - If Stall=0 and HoldValid=1, IF/ID <= hold, HoldValid <= 0, launch at Pc in the same cycle.
- BUSY, ImemReady=0: hold; ImemAddr is unchanged.
- BUSY, ImemReady=1, Stall=0: IF/ID <= {1, ReqAddr, ImemRdata}; Pc <= ReqAddr+4; launch at ReqAddr+4 (back-to-back).
- BUSY, ImemReady=1, Stall=1: hold <= {ReqAddr, ImemRdata}; Pc <= ReqAddr+4; state <= IDLE; IF/ID unchanged.
- Stall=0 and no instruction loaded this cycle: IfIdValid <= 0 (bubble).
- DROP: on ImemReady=1, discard data; launch at Pc if Stall=0, else go to IDLE.
- Redirect has priority over Stall and over normal completion:
  - IfIdValid <= 0 and HoldValid <= 0.
  - Pc <= {RedirectPc[31:2], 2'b00}.
  - BUSY with ImemReady=0 -> DROP. ReqAddr is held, per the protocol.
  - BUSY or DROP with ImemReady=1: data discarded; launch at the redirect target if Stall=0, else go to IDLE.
  - Redirect in IDLE or DROP with ImemReady=0: only Pc updates; a DROP stays in DROP.
- Arithmetic: all +4 wraps mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).

## Timing
- Reset values (cycle after any RstN=0 edge):
  - state=IDLE, ImemReq=0.
  - Pc=ReqAddr=ImemAddr=RESET_PC.
  - HoldValid=0, IfIdValid=0, IfIdPc=0, IfIdInstr=0, PcP4=4.
- Reset mid-request abandons it. Instruction memory shares RstN.
- First request: ImemReq=1 in the 1st cycle after RstN rises, given Stall=0.
- Fetch latency: instruction appears in IF/ID the cycle after ImemReady.
- Zero-wait memory gives 1 instruction/cycle.
- N wait cycles add N bubbles per instruction.
- Stall release with a full hold buffer: IF/ID updates and the next request issues on the same edge.

## Test plan
- Zero-wait memory, ImemReady tied 1, Stall=0, RESET_PC=0 -> ImemAddr 0,4,8 on cycles 1,2,3; IfIdPc 0,4 valid on cycles 2,3; PcP4=8 on cycle 3.
- ImemReady low 2 cycles for address 0x4 -> ImemAddr held 0x4 for 3 cycles; IfIdValid=0 for 2 bubble cycles; then IfIdPc=0x4.
- Redirect to 0x100 while the 0x8 request waits -> ImemAddr stays 0x8 until ImemReady; that word is never loaded into IF/ID; next ImemAddr=0x100; IfIdValid=0 until the 0x100 word arrives.
- Stall=1 when the 0xC word completes -> IF/ID unchanged and ImemReq=0 while stalled. Stall falls -> IfIdPc=0xC valid, and ImemAddr=0x10 with ImemReq=1 on the same edge.
- Redirect to 0xFFFF_FFFF -> ImemAddr=0xFFFF_FFFC, then 0x0000_0000; PcP4=0 when the 0xFFFF_FFFC word is in IF/ID.
- RstN=0 for one cycle while in DROP, with Redirect also asserted -> next cycle shows all reset values, ImemReq=0, Pc=RESET_PC.
